// File: rtl/apb_fifo_if.sv
// APB slave bus bundle for apb_fifo.
// Master drives address/control/write data; slave returns read data and ready.
interface apb_fifo_if;
    logic [3:0]  PADDR;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    modport master (
        output PADDR, PWRITE, PSEL, PENABLE, PWDATA,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PADDR, PWRITE, PSEL, PENABLE, PWDATA,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/apb_fifo.sv
// APB-mapped FIFO with FSR/FWD/FRD/FCR registers and one wait state.
// Define APB_FIFO_ERR_EN to build sticky overflow/underflow flags.
module apb_fifo #(
    parameter int DEPTH = 8,
    parameter int DW    = 8
) (
    input  logic      PCLK,
    input  logic      PRESET,
    apb_fifo_if.slave bus,
    output logic      fifo_empty,
    output logic      fifo_full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic { IDLE, RESP } state_t;
    typedef enum logic [1:0] {
        A_FSR, A_FWD, A_FRD, A_FCR
    } reg_t;

    state_t        state, state_nx;
    reg_t          addr;
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [31:0]   prdata, rdata, fsr;
    logic          ovf, udf;
    logic          commit, push, pop, clr;
    logic          unused_bits;

    assign addr   = reg_t'(bus.PADDR[3:2]);
    assign commit = (state == IDLE) && bus.PSEL && bus.PENABLE;
    assign push   = commit && bus.PWRITE && (addr == A_FWD);
    assign pop    = commit && !bus.PWRITE && (addr == A_FRD);
    assign clr    = commit && bus.PWRITE && (addr == A_FCR)
                    && bus.PWDATA[0];

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(DEPTH));

    assign bus.PREADY = (state == RESP);
    assign bus.PRDATA = prdata;

    assign unused_bits = ^{bus.PADDR[1:0], bus.PWDATA[31:DW]};

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (bus.PSEL && bus.PENABLE) state_nx = RESP;
            RESP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign fsr = {23'd0, 5'(count), udf, ovf, fifo_full, fifo_empty};

    always_comb begin
        rdata = 32'd0;
        unique case (addr)
            A_FSR: rdata = fsr;
            A_FRD: if (!fifo_empty) rdata = 32'(mem[rd_ptr]);
            default: rdata = 32'd0;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET)                        prdata <= 32'd0;
        else if (commit && !bus.PWRITE)    prdata <= rdata;
    end

    // Storage is never reset; only pointers and count define validity.
    always_ff @(posedge PCLK) begin
        if (push && !fifo_full) mem[wr_ptr] <= bus.PWDATA[DW-1:0];
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (push && !fifo_full) begin
            wr_ptr <= wr_ptr + AW'(1);
            count  <= count + CW'(1);
        end else if (pop && !fifo_empty) begin
            rd_ptr <= rd_ptr + AW'(1);
            count  <= count - CW'(1);
        end
    end

`ifdef APB_FIFO_ERR_EN
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else if (clr) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (push && fifo_full)  ovf <= 1'b1;
            if (pop && fifo_empty)  udf <= 1'b1;
        end
    end
`else
    assign ovf = 1'b0;
    assign udf = 1'b0;
`endif
endmodule

// File: tb/tb_apb_fifo.sv
// Self-checking bench for apb_fifo: directed register scenarios
// followed by random APB traffic against a queue-based model.
module tb_apb_fifo;
    localparam int DEPTH = 8;
    localparam int DW    = 8;
`ifdef APB_FIFO_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic PCLK = 1'b0;
    logic PRESET;
    logic fifo_empty, fifo_full;

    apb_fifo_if bus();

    apb_fifo #(.DEPTH(DEPTH), .DW(DW)) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .bus        (bus),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q[$];
    logic          m_ovf, m_udf;
    logic [31:0]   m_prdata;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fsr_model();
        logic e, f;
        e = (q.size() == 0);
        f = (q.size() == DEPTH);
        return {23'd0, 5'(q.size()), m_udf, m_ovf, f, e};
    endfunction

    task automatic model_reset();
        q.delete();
        m_ovf    = 1'b0;
        m_udf    = 1'b0;
        m_prdata = 32'd0;
    endtask

    // Expected PRDATA after the transfer, updating the model state.
    task automatic model(input logic w, input logic [3:0] a,
                         input logic [31:0] d,
                         output logic [31:0] exp);
        logic [31:0] r;
        r = 32'd0;
        case (a[3:2])
            2'd0: r = fsr_model();
            2'd1: if (w) begin
                if (q.size() < DEPTH) q.push_back(d[DW-1:0]);
                else if (ERR) m_ovf = 1'b1;
            end
            2'd2: if (!w) begin
                if (q.size() > 0) r = 32'(q.pop_front());
                else if (ERR) m_udf = 1'b1;
            end
            default: if (w && d[0]) begin
                q.delete();
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end
        endcase
        if (!w) m_prdata = r;
        exp = m_prdata;
    endtask

    task automatic xfer(input logic w, input logic [3:0] a,
                        input logic [31:0] d,
                        output logic [31:0] rd);
        logic [31:0] exp;
        int waits;
        model(w, a, d, exp);
        @(negedge PCLK);
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = w;
        bus.PADDR   = a;
        bus.PWDATA  = d;
        @(negedge PCLK);
        bus.PENABLE = 1'b1;
        #1;
        waits = 0;
        while (!bus.PREADY && waits < 4) begin
            @(negedge PCLK);
            waits++;
        end
        chk("wait_states", 32'(waits), 32'd1);
        rd = bus.PRDATA;
        chk(w ? "prdata_hold" : "rdata", rd, exp);
        @(negedge PCLK);
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        #1;
        chk("empty", 32'(fifo_empty), 32'(q.size() == 0));
        chk("full", 32'(fifo_full), 32'(q.size() == DEPTH));
    endtask

    logic [31:0] rd;

    initial begin
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = 4'd0;
        bus.PWDATA  = 32'd0;
        PRESET      = 1'b1;
        model_reset();
        #2;
        chk("rst_pready", 32'(bus.PREADY), 32'd0);
        chk("rst_prdata", bus.PRDATA, 32'd0);
        chk("rst_empty", 32'(fifo_empty), 32'd1);
        chk("rst_full", 32'(fifo_full), 32'd0);
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;

        xfer(1'b0, 4'h0, 32'd0, rd);
        chk("fsr_reset", rd, 32'h1);

        for (int i = 0; i < 8; i++)
            xfer(1'b1, 4'h4, 32'hA1 + 32'(i), rd);
        xfer(1'b0, 4'h0, 32'd0, rd);
        chk("fsr_full", rd, 32'h82);
        xfer(1'b1, 4'h4, 32'hFF, rd);
        xfer(1'b0, 4'h0, 32'd0, rd);
        chk("fsr_ovf", rd, ERR ? 32'h86 : 32'h82);

        for (int i = 0; i < 8; i++) begin
            xfer(1'b0, 4'h8, 32'd0, rd);
            chk("pop_a", rd, 32'hA1 + 32'(i));
        end
        xfer(1'b0, 4'h8, 32'd0, rd);
        chk("pop_empty", rd, 32'd0);
        xfer(1'b0, 4'h0, 32'd0, rd);
        chk("fsr_udf", 32'(rd[3]), 32'(ERR));

        xfer(1'b1, 4'hC, 32'h1, rd);
        for (int i = 0; i < 5; i++)
            xfer(1'b1, 4'h4, 32'h10 + 32'(i), rd);
        for (int i = 0; i < 5; i++)
            xfer(1'b0, 4'h8, 32'd0, rd);
        for (int i = 0; i < 8; i++)
            xfer(1'b1, 4'h4, 32'hB0 + 32'(i), rd);
        for (int i = 0; i < 8; i++) begin
            xfer(1'b0, 4'h8, 32'd0, rd);
            chk("pop_wrap", rd, 32'hB0 + 32'(i));
        end
        xfer(1'b0, 4'h0, 32'd0, rd);
        chk("fsr_wrap", rd, 32'h1);

        for (int i = 0; i < 3; i++)
            xfer(1'b1, 4'h4, 32'h30 + 32'(i), rd);
        xfer(1'b1, 4'hC, 32'h1, rd);
        xfer(1'b0, 4'h0, 32'd0, rd);
        chk("fsr_clr", rd, 32'h1);
        xfer(1'b0, 4'hC, 32'd0, rd);
        chk("fcr_read", rd, 32'd0);
        xfer(1'b1, 4'h4, 32'h5A, rd);
        xfer(1'b0, 4'h8, 32'd0, rd);
        chk("roundtrip", rd, 32'h5A);

        // Reset while the push response is on the bus.
        @(negedge PCLK);
        bus.PSEL   = 1'b1;
        bus.PWRITE = 1'b1;
        bus.PADDR  = 4'h4;
        bus.PWDATA = 32'h77;
        @(negedge PCLK);
        bus.PENABLE = 1'b1;
        @(posedge PCLK);
        #1;
        chk("resp_ready", 32'(bus.PREADY), 32'd1);
        PRESET = 1'b1;
        #1;
        chk("abort_ready", 32'(bus.PREADY), 32'd0);
        chk("abort_empty", 32'(fifo_empty), 32'd1);
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        model_reset();
        @(negedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b0;
        xfer(1'b0, 4'h0, 32'd0, rd);
        chk("fsr_after_rst", rd, 32'h1);

        for (int n = 0; n < 400; n++) begin
            int unsigned sel;
            logic [3:0]  a;
            logic [31:0] d;
            logic        w;
            sel = $urandom_range(0, 9);
            a   = 4'($urandom);
            d   = $urandom;
            w   = 1'($urandom);
            if (sel < 4) begin
                a[3:2] = 2'd1;
                w      = 1'b1;
            end else if (sel < 8) begin
                a[3:2] = 2'd2;
                w      = 1'b0;
            end
            if (a[3:2] == 2'd3 && w)
                d[0] = ($urandom_range(0, 7) == 0);
            xfer(w, a, d, rd);
        end
        xfer(1'b0, 4'h0, 32'd0, rd);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/apb_fifo.md
APB_FIFO -- requirements
Module: apb_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter DW, default 8, FIFO entry width in bits (1..24).
REQ-003 SHALL have port PCLK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port PRESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port PADDR  input  4  register byte address; bits [1:0] ignored.
REQ-006 SHALL have ports PWRITE, PSEL and PENABLE, each input, 1 bit, with APB meaning.
REQ-007 SHALL have port PWDATA  input  32  write data.
REQ-008 SHALL have port PRDATA  output  32  registered read data.
REQ-009 SHALL have port PREADY  output  1  transfer-complete strobe.
REQ-010 SHALL have ports fifo_empty and fifo_full, each output, 1 bit, live flags driven from registered count.

Function
REQ-011 Register map SHALL be: 0x0 FSR (read-only), 0x4 FWD (write-only push), 0x8 FRD (read-only pop), 0xC FCR (read/write control).
REQ-012 FSR layout SHALL be [0]=empty, [1]=full, [2]=overflow, [3]=underflow, [8:4]=count (0..DEPTH), all other bits 0.
REQ-013 FCR layout SHALL be bit0 CLR (write 1: empty FIFO and clear sticky flags; self-clearing, reads 0) and other bits reserved (read 0).
REQ-014 State machine SHALL have two states: IDLE and RESP.
- IDLE -> RESP when PSEL=1 and PENABLE=1.
- RESP -> IDLE unconditionally after one cycle.
REQ-015 The register action (push, pop, CLR, read capture) SHALL commit on the IDLE->RESP clock edge, exactly once per transfer.
REQ-016 PREADY SHALL be 1 only in RESP, giving exactly one wait state: setup cycle, access cycle with PREADY=0, access cycle with PREADY=1.
REQ-017 PRDATA SHALL be loaded on the IDLE->RESP edge for reads and hold its value otherwise; write transfers leave PRDATA unchanged.
REQ-018 A write to FWD with count<DEPTH SHALL store PWDATA[DW-1:0] at wr_ptr, increment wr_ptr modulo DEPTH, and increment count.
REQ-019 A write to FWD with count==DEPTH SHALL drop the data and leave pointers and count unchanged.
REQ-020 A read of FRD with count>0 SHALL return the head entry zero-extended to 32 bits, increment rd_ptr modulo DEPTH, and decrement count.
REQ-021 A read of FRD with count==0 SHALL return 0 and leave pointers and count unchanged.
REQ-022 Pointers SHALL be log2(DEPTH) bits and wrap naturally; count SHALL be log2(DEPTH)+1 bits and never exceed DEPTH.
REQ-023 Writes to FSR or FRD SHALL be ignored; reads of FWD SHALL return 0.
REQ-024 If PSEL drops while in RESP, the block SHALL still return to IDLE, and the committed action SHALL stand.
REQ-025 A new transfer SHALL NOT be accepted in RESP; the back-to-back minimum is setup, wait, ready.

Reset
REQ-026 While PRESET=1, regardless of PCLK, the block SHALL hold state=IDLE, PREADY=0, PRDATA=0, pointers=0, count=0, sticky flags=0, fifo_empty=1, fifo_full=0.
REQ-027 An assertion of PRESET during RESP SHALL abort the transfer immediately.
REQ-028 After PRESET deasserts, the next transfer SHALL start from IDLE.
REQ-029 FIFO storage contents SHALL NOT need reset.

Configuration
REQ-030 Macro APB_FIFO_ERR_EN defined: a push while full SHALL set FSR[2], and a pop while empty SHALL set FSR[3]; both bits stay set until FCR CLR or reset.
REQ-031 Macro APB_FIFO_ERR_EN undefined: FSR[3:2] SHALL read 0 and no flag storage SHALL be built; all other behaviour SHALL be identical.

Verification
REQ-032 Reset, then read FSR -> PRDATA=0x00000001, PREADY=1 on the third transfer cycle, fifo_empty=1.
REQ-033 Push 0xA1..0xA8 to FWD -> FSR=0x00000082, fifo_full=1; a 9th push of 0xFF is dropped; with APB_FIFO_ERR_EN, FSR=0x00000086.
REQ-034 Pop FRD 8 times -> data 0xA1..0xA8 in order; a 9th pop returns 0; with APB_FIFO_ERR_EN, FSR[3]=1.
REQ-035 Wrap test, DEPTH=8: push 5, pop 5, push 8 (0xB0..0xB7), pop 8 -> 0xB0..0xB7 in order, pointers wrap correctly, final FSR=0x00000001.
REQ-036 Push 3 entries, write FCR=0x1 -> FSR=0x00000001 and FCR reads 0; next push/pop round-trips 0x5A.
REQ-037 Assert PRESET in the cycle after a FWD push commits (RESP) -> PREADY=0 at once, FSR=0x00000001 after release.
